// File: rtl/lpddr5_cmd_timing_checker.sv
// LPDDR5 command-stream timing checker: decodes two-beat CA/CS commands, tracks
// per-bank open state and spacing timers, and reports protocol violations.
module lpddr5_cmd_timing_checker #(
  parameter int NUM_BANKS  = 16,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4,
  parameter int T_RAS      = 8,
  parameter int T_RFC      = 20,
  parameter int T_REFI_MAX = 800,
  parameter int CNT_W      = 16,
  parameter int ERR_W      = 8
) (
  input  logic                 ck_t,
  input  logic                 ddr_reset_n,
  input  logic                 cs,
  input  logic [6:0]           ca,
  input  logic                 en,
  input  logic                 clr,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_code,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [9:0]           viol_pulse,
  output logic [9:0]           viol_sticky,
  output logic [ERR_W-1:0]     viol_count
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BEAT1 = 1'b1} state_e;

  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_PREA = 3'd5;
  localparam logic [2:0] C_REF  = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RCD_C     = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] RP_C      = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] RAS_C     = CNT_W'(T_RAS);
  localparam logic [CNT_W-1:0] RFC_C     = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0] REFI_C    = CNT_W'(T_REFI_MAX);
  localparam logic [ERR_W-1:0] ERR_ZERO_C = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_MAX_C  = {ERR_W{1'b1}};
  localparam logic [4:0]       NB_C       = 5'(NUM_BANKS);

  function automatic logic [2:0] decode_op(input logic [6:0] op);
    case (op)
      7'h70:   decode_op = C_ACT;
      7'h40:   decode_op = C_RD;
      7'h30:   decode_op = C_WR;
      7'h0F:   decode_op = C_PRE;
      7'h1F:   decode_op = C_PREA;
      7'h0E:   decode_op = C_REF;
      default: decode_op = C_ILL;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX_C) ? v : v + CNT_W'(1);
  endfunction

  state_e                 state_q, state_d;
  logic [6:0]             opcode_q, opcode_d;
  logic [NUM_BANKS-1:0]   open_q, open_d;
  logic [CNT_W-1:0]       tmr_q [NUM_BANKS];
  logic [CNT_W-1:0]       tmr_d [NUM_BANKS];
  logic [CNT_W-1:0]       dist_s [NUM_BANKS];
  logic [NUM_BANKS-1:0]   sel_s;
  logic [CNT_W-1:0]       rtmr_q, rtmr_d, rinc_s;
  logic                   armed_q, armed_d, refi_hit_s;
  logic                   s1_valid_q, s1_valid_d;
  logic [2:0]             s1_code_q, s1_code_d;
  logic [9:0]             s1_viol_q, s1_viol_d;
  logic                   valid_q, valid_d;
  logic [2:0]             code_q, code_d;
  logic [9:0]             pulse_q, pulse_d;
  logic [9:0]             sticky_q, sticky_d;
  logic [ERR_W-1:0]       count_q, count_d;

  logic                   issue_s, bank_ok_s;
  logic [2:0]             code_s;
  logic [3:0]             bank_s;
  logic                   act_s, rdwr_s, pre_s, prea_s, ref_s;
  logic [4:0]             bank_viol_s;
  logic [9:0]             viol_s;

  // The command takes effect on the edge that samples beat 1.
  assign issue_s   = (state_q == ST_BEAT1);
  assign code_s    = decode_op(opcode_q);
  assign bank_s    = ca[3:0];
  assign bank_ok_s = ({1'b0, bank_s} < NB_C);
  assign act_s     = issue_s && (code_s == C_ACT);
  assign rdwr_s    = issue_s && ((code_s == C_RD) || (code_s == C_WR));
  assign pre_s     = issue_s && (code_s == C_PRE);
  assign prea_s    = issue_s && (code_s == C_PREA);
  assign ref_s     = issue_s && (code_s == C_REF);

  // Two-beat command framing.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          state_d  = ST_BEAT1;
          opcode_d = ca;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BEAT1: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Distance counts edges since the clearing command, so beat1-to-beat1 spacing of N gives N.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      dist_s[b] = sat_inc(tmr_q[b]);
      sel_s[b]  = issue_s && bank_ok_s && (bank_s == 4'(b));
    end
  end

  // Per-bank state and spacing checks; RCD/RAS only apply to an open bank, RP to a closed one.
  always_comb begin
    open_d      = open_q;
    bank_viol_s = 5'b00000;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (prea_s) begin
        open_d[b] = 1'b0;
        tmr_d[b]  = ZERO_C;
      end else if (sel_s[b] && act_s) begin
        open_d[b] = 1'b1;
        tmr_d[b]  = ZERO_C;
      end else if (sel_s[b] && pre_s) begin
        open_d[b] = 1'b0;
        tmr_d[b]  = ZERO_C;
      end else begin
        open_d[b] = open_q[b];
        tmr_d[b]  = dist_s[b];
      end
      bank_viol_s[0] = bank_viol_s[0] | (sel_s[b] && rdwr_s && open_q[b] && (dist_s[b] < RCD_C));
      bank_viol_s[1] = bank_viol_s[1] | (sel_s[b] && act_s && !open_q[b] && (dist_s[b] < RP_C));
      bank_viol_s[2] = bank_viol_s[2] | (sel_s[b] && pre_s && open_q[b] && (dist_s[b] < RAS_C));
      bank_viol_s[3] = bank_viol_s[3] | (sel_s[b] && rdwr_s && !open_q[b]);
      bank_viol_s[4] = bank_viol_s[4] | (sel_s[b] && act_s && open_q[b]);
    end
  end

  // Refresh timer; the interval check fires once and disarms until the next REF.
  always_comb begin
    rinc_s = sat_inc(rtmr_q);
    if (ref_s) begin
      rtmr_d     = ZERO_C;
      armed_d    = 1'b1;
      refi_hit_s = 1'b0;
    end else if (armed_q && (rinc_s == REFI_C)) begin
      rtmr_d     = rinc_s;
      armed_d    = 1'b0;
      refi_hit_s = 1'b1;
    end else begin
      rtmr_d     = rinc_s;
      armed_d    = armed_q;
      refi_hit_s = 1'b0;
    end
  end

  assign viol_s = {issue_s && cs,
                   issue_s && (code_s == C_ILL),
                   refi_hit_s,
                   act_s && bank_ok_s && (rinc_s < RFC_C),
                   ref_s && (|open_q),
                   bank_viol_s};

  // Detection stage followed by the registered reporting stage.
  always_comb begin
    s1_valid_d = issue_s;
    s1_code_d  = issue_s ? code_s : 3'd0;
    s1_viol_d  = en ? viol_s : 10'd0;
    valid_d    = s1_valid_q;
    code_d     = s1_code_q;
    pulse_d    = s1_viol_q;
    if (clr) begin
      sticky_d = 10'd0;
      count_d  = ERR_ZERO_C;
    end else begin
      sticky_d = sticky_q | s1_viol_q;
      count_d  = ((|s1_viol_q) && (count_q != ERR_MAX_C)) ? count_q + ERR_W'(1) : count_q;
    end
  end

  // State registers; reset aborts any partial command.
  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      state_q    <= ST_IDLE;
      opcode_q   <= 7'h00;
      open_q     <= {NUM_BANKS{1'b0}};
      for (int b = 0; b < NUM_BANKS; b++) tmr_q[b] <= CNT_MAX_C;
      rtmr_q     <= CNT_MAX_C;
      armed_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_code_q  <= 3'd0;
      s1_viol_q  <= 10'd0;
      valid_q    <= 1'b0;
      code_q     <= 3'd0;
      pulse_q    <= 10'd0;
      sticky_q   <= 10'd0;
      count_q    <= ERR_ZERO_C;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      open_q     <= open_d;
      for (int b = 0; b < NUM_BANKS; b++) tmr_q[b] <= tmr_d[b];
      rtmr_q     <= rtmr_d;
      armed_q    <= armed_d;
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_viol_q  <= s1_viol_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      pulse_q    <= pulse_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign cmd_valid   = valid_q;
  assign cmd_code    = code_q;
  assign bank_open   = open_q;
  assign viol_pulse  = pulse_q;
  assign viol_sticky = sticky_q;
  assign viol_count  = count_q;

endmodule

// File: tb/tb_lpddr5_cmd_timing_checker.sv
// Directed bench for lpddr5_cmd_timing_checker: a vector table of single commands
// plus hand-written sequences for refresh interval, saturation, clear and reset.
module tb_lpddr5_cmd_timing_checker;

  logic        ck_t = 1'b0;
  logic        ddr_reset_n;
  logic        cs;
  logic [6:0]  ca;
  logic        en;
  logic        clr;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [15:0] bank_open;
  logic [9:0]  viol_pulse;
  logic [9:0]  viol_sticky;
  logic [7:0]  viol_count;

  int checks = 0;
  int errors = 0;

  lpddr5_cmd_timing_checker dut (
    .ck_t(ck_t), .ddr_reset_n(ddr_reset_n), .cs(cs), .ca(ca), .en(en), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .bank_open(bank_open),
    .viol_pulse(viol_pulse), .viol_sticky(viol_sticky), .viol_count(viol_count)
  );

  always #5 ck_t = ~ck_t;

  typedef struct {
    logic [6:0]  op;
    logic [3:0]  bank;
    logic        coll;
    logic        en;
    int          gap;
    logic [2:0]  code;
    logic [9:0]  viol;
    logic [15:0] open;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat 0 and beat 1 driven on successive falling edges; returns just after the issue edge.
  task automatic issue(input logic [6:0] op, input logic [3:0] bank, input logic coll);
    cs = 1'b1;
    ca = op;
    @(negedge ck_t);
    cs = coll;
    ca = {3'b000, bank};
    @(negedge ck_t);
    cs = 1'b0;
    ca = 7'h00;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge ck_t);
    clr = 1'b0;
  endtask

  int first_k;
  int pulses;
  int spurious;

  initial begin
    // Issue-to-issue distance between rows is gap + 3.
    vecs[0]  = '{7'h70, 4'd3,  1'b0, 1'b1, 0,  3'd1, 10'h000, 16'h0008};
    vecs[1]  = '{7'h40, 4'd3,  1'b0, 1'b1, 3,  3'd2, 10'h000, 16'h0008};
    vecs[2]  = '{7'h70, 4'd5,  1'b0, 1'b1, 0,  3'd1, 10'h000, 16'h0028};
    vecs[3]  = '{7'h40, 4'd5,  1'b0, 1'b1, 0,  3'd2, 10'h001, 16'h0028};
    vecs[4]  = '{7'h70, 4'd6,  1'b0, 1'b1, 0,  3'd1, 10'h000, 16'h0068};
    vecs[5]  = '{7'h30, 4'd6,  1'b0, 1'b1, 1,  3'd3, 10'h000, 16'h0068};
    vecs[6]  = '{7'h40, 4'd7,  1'b0, 1'b1, 0,  3'd2, 10'h008, 16'h0068};
    vecs[7]  = '{7'h70, 4'd7,  1'b0, 1'b1, 0,  3'd1, 10'h000, 16'h00E8};
    vecs[8]  = '{7'h70, 4'd7,  1'b0, 1'b1, 7,  3'd1, 10'h010, 16'h00E8};
    vecs[9]  = '{7'h0F, 4'd7,  1'b0, 1'b1, 4,  3'd4, 10'h004, 16'h0068};
    vecs[10] = '{7'h70, 4'd7,  1'b0, 1'b1, 0,  3'd1, 10'h002, 16'h00E8};
    vecs[11] = '{7'h0F, 4'd7,  1'b0, 1'b1, 5,  3'd4, 10'h000, 16'h0068};
    vecs[12] = '{7'h70, 4'd7,  1'b0, 1'b1, 1,  3'd1, 10'h000, 16'h00E8};
    vecs[13] = '{7'h0E, 4'd0,  1'b0, 1'b1, 0,  3'd6, 10'h020, 16'h00E8};
    vecs[14] = '{7'h1F, 4'd0,  1'b0, 1'b1, 0,  3'd5, 10'h000, 16'h0000};
    vecs[15] = '{7'h0E, 4'd0,  1'b0, 1'b1, 0,  3'd6, 10'h000, 16'h0000};
    vecs[16] = '{7'h70, 4'd1,  1'b0, 1'b1, 2,  3'd1, 10'h040, 16'h0002};
    vecs[17] = '{7'h70, 4'd2,  1'b0, 1'b1, 12, 3'd1, 10'h000, 16'h0006};
    vecs[18] = '{7'h55, 4'd0,  1'b0, 1'b1, 0,  3'd7, 10'h100, 16'h0006};
    vecs[19] = '{7'h40, 4'd9,  1'b0, 1'b0, 0,  3'd2, 10'h000, 16'h0006};
    vecs[20] = '{7'h0F, 4'd1,  1'b0, 1'b1, 0,  3'd4, 10'h000, 16'h0004};
    vecs[21] = '{7'h0F, 4'd9,  1'b0, 1'b1, 0,  3'd4, 10'h000, 16'h0004};
    vecs[22] = '{7'h70, 4'd8,  1'b1, 1'b1, 0,  3'd1, 10'h200, 16'h0104};

    ddr_reset_n = 1'b0;
    cs  = 1'b0;
    ca  = 7'h00;
    en  = 1'b1;
    clr = 1'b0;
    repeat (3) @(negedge ck_t);
    ddr_reset_n = 1'b1;
    @(negedge ck_t);
    chk("reset cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("reset cmd_code", {29'd0, cmd_code}, 32'd0);
    chk("reset bank_open", {16'd0, bank_open}, 32'd0);
    chk("reset viol_sticky", {22'd0, viol_sticky}, 32'd0);
    chk("reset viol_count", {24'd0, viol_count}, 32'd0);

    for (int i = 0; i < 23; i++) begin
      repeat (vecs[i].gap) @(negedge ck_t);
      en = vecs[i].en;
      issue(vecs[i].op, vecs[i].bank, vecs[i].coll);
      @(negedge ck_t);
      en = 1'b1;
      chk($sformatf("vec%0d cmd_valid", i), {31'd0, cmd_valid}, 32'd1);
      chk($sformatf("vec%0d cmd_code", i), {29'd0, cmd_code}, {29'd0, vecs[i].code});
      chk($sformatf("vec%0d viol_pulse", i), {22'd0, viol_pulse}, {22'd0, vecs[i].viol});
      chk($sformatf("vec%0d bank_open", i), {16'd0, bank_open}, {16'd0, vecs[i].open});
    end
    chk("table viol_sticky", {22'd0, viol_sticky}, 32'h37F);
    chk("table viol_count", {24'd0, viol_count}, 32'd9);

    // RD two cycles after ACT, back to back.
    pulse_clr();
    chk("clr sticky", {22'd0, viol_sticky}, 32'd0);
    chk("clr count", {24'd0, viol_count}, 32'd0);
    issue(7'h70, 4'd10, 1'b0);
    issue(7'h40, 4'd10, 1'b0);
    @(negedge ck_t);
    chk("trcd2 code", {29'd0, cmd_code}, 32'd2);
    chk("trcd2 pulse", {22'd0, viol_pulse}, 32'h001);
    @(negedge ck_t);
    chk("trcd2 pulse width", {22'd0, viol_pulse}, 32'd0);
    chk("trcd2 valid width", {31'd0, cmd_valid}, 32'd0);
    chk("trcd2 sticky", {22'd0, viol_sticky}, 32'h001);
    chk("trcd2 count", {24'd0, viol_count}, 32'd1);

    // Missed refresh interval: pulse exactly once, 801 falling edges after issue.
    issue(7'h1F, 4'd0, 1'b0);
    issue(7'h0E, 4'd0, 1'b0);
    first_k = 0;
    pulses  = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge ck_t);
      if (viol_pulse[7]) begin
        if (first_k == 0) first_k = k;
        pulses++;
      end
    end
    chk("refi first pulse edge", first_k, 32'd801);
    chk("refi pulse count", pulses, 32'd1);
    chk("refi sticky bit7", {31'd0, viol_sticky[7]}, 32'd1);
    issue(7'h0E, 4'd0, 1'b0);
    @(negedge ck_t);
    chk("rearm ref code", {29'd0, cmd_code}, 32'd6);
    chk("rearm ref pulse", {22'd0, viol_pulse}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge ck_t);
      if (viol_pulse != 10'd0) pulses++;
    end
    chk("rearm quiet", pulses, 32'd0);

    // Counter saturation with 256 illegal commands.
    pulse_clr();
    for (int i = 0; i < 256; i++) issue(7'h55, 4'd0, 1'b0);
    @(negedge ck_t);
    chk("sat count", {24'd0, viol_count}, 32'd255);
    chk("sat sticky", {22'd0, viol_sticky}, 32'h100);
    pulse_clr();
    chk("sat clr count", {24'd0, viol_count}, 32'd0);
    chk("sat clr sticky", {22'd0, viol_sticky}, 32'd0);

    // clr on the same edge as a new violation: the violation is not accumulated.
    issue(7'h55, 4'd0, 1'b0);
    pulse_clr();
    chk("clr wins sticky", {22'd0, viol_sticky}, 32'd0);
    chk("clr wins count", {24'd0, viol_count}, 32'd0);
    @(negedge ck_t);
    chk("clr lost sticky", {22'd0, viol_sticky}, 32'd0);
    chk("clr lost count", {24'd0, viol_count}, 32'd0);

    // Asynchronous reset in the middle of a command.
    issue(7'h70, 4'd2, 1'b0);
    issue(7'h55, 4'd0, 1'b0);
    cs = 1'b1;
    ca = 7'h70;
    @(negedge ck_t);
    cs = 1'b0;
    ca = 7'h00;
    #2;
    ddr_reset_n = 1'b0;
    #1;
    chk("async cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("async cmd_code", {29'd0, cmd_code}, 32'd0);
    chk("async bank_open", {16'd0, bank_open}, 32'd0);
    chk("async viol_pulse", {22'd0, viol_pulse}, 32'd0);
    chk("async viol_sticky", {22'd0, viol_sticky}, 32'd0);
    chk("async viol_count", {24'd0, viol_count}, 32'd0);
    @(negedge ck_t);
    ddr_reset_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ck_t);
      if (cmd_valid) spurious++;
    end
    chk("partial discarded", spurious, 32'd0);
    issue(7'h70, 4'd4, 1'b0);
    @(negedge ck_t);
    chk("post reset code", {29'd0, cmd_code}, 32'd1);
    chk("post reset pulse", {22'd0, viol_pulse}, 32'd0);
    chk("post reset open", {16'd0, bank_open}, 32'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpddr5_cmd_timing_checker.md
Name: lpddr5_cmd_timing_checker

Overview:
Synthesizable, parametrised successor to the channel-interface protocol assertions. It decodes the two-beat LPDDR5 command stream on CA/CS and tracks per-bank open/closed state. It times ACT/RD/WR/PRE/REF spacing with per-bank counters and reports violations as sticky flags, pulses and a saturating count. It sits beside each LPDDR5 channel, in the agent monitor path and as an emulation-side checker.

Parameters:
NUM_BANKS, 16, banks tracked (1..16); bank index = ca[3:0], upper values ignored
T_RCD, 4, min beat1-to-beat1 cycles ACT->RD/WR, same bank
T_RP, 4, min cycles PRE->ACT, same bank
T_RAS, 8, min cycles ACT->PRE, same bank
T_RFC, 20, min cycles REF->any ACT
T_REFI_MAX, 800, max cycles between consecutive REFs
CNT_W, 16, per-bank/refresh timer width; all T_* < 2**CNT_W
ERR_W, 8, violation counter width

Ports:
ck_t  in  1  command clock, posedge sampling
ddr_reset_n  in  1  reset, asynchronous, active-low
cs  in  1  chip select (cs0|cs1)
ca  in  7  command/address bus
en  in  1  1 = record violations; bank tracking always runs
clr  in  1  synchronous clear of viol_sticky/viol_count
cmd_valid  out  1  1-cycle pulse, decoded command complete
cmd_code  out  3  0 NOP,1 ACT,2 RD,3 WR,4 PRE,5 PREA,6 REF,7 ILLEGAL
bank_open  out  NUM_BANKS  per-bank open state
viol_pulse  out  10  violations detected this cycle
viol_sticky  out  10  OR-accumulated violations
viol_count  out  ERR_W  saturating count of cycles with any viol_pulse bit

Behaviour:
- Reset: all outputs 0, FSM IDLE, all bank timers and refresh timer saturated (all-ones), refresh check disarmed.
- Beat0 opcodes (ca, cs=1): ACT 7'h70, RD 7'h40, WR 7'h30, PRE 7'h0F, PREA 7'h1F, REF 7'h0E. Any other value = ILLEGAL.
- FSM IDLE: cs=1 captures ca into opcode register -> BEAT1. BEAT1: ca[3:0] = bank, -> IDLE. Command takes effect at the BEAT1 edge ("issue cycle").
- cs=1 during BEAT1: viol bit9 (collision). The beat is consumed as bank data, never as a new opcode.
- Outputs are registered. cmd_valid/cmd_code/viol_pulse assert on the edge after the issue cycle, for exactly 1 cycle.
- Bank timers: cleared to 0 at the issue cycle of ACT/PRE to that bank (PREA: all banks). Incremented every ck_t otherwise, saturating at all-ones. Distance = timer value at the issue cycle.
- Violation bits:
  - [0] RD/WR with distance < T_RCD
  - [1] ACT with distance since PRE < T_RP
  - [2] PRE with distance since ACT < T_RAS
  - [3] RD/WR to closed bank
  - [4] ACT to open bank
  - [5] REF while any bank open
  - [6] ACT with refresh timer < T_RFC
  - [7] refresh timer reaches T_REFI_MAX while armed
  - [8] ILLEGAL opcode
  - [9] collision
- Bit7 arms at the first REF, fires once per missed interval, then holds until the next REF restarts the timer.
- State updates regardless of violation: ACT sets bank_open, PRE clears it, PREA clears all. RD/WR leave state unchanged.
- Bank index >= NUM_BANKS: command ignored, no violation.
- en=0: viol_pulse, sticky and count are not updated; decode and state continue.
- clr and a new violation in the same cycle: clr wins for that cycle, and the new violation is lost.
- viol_count saturates at 2**ERR_W-1 with no wrap.
- Async reset mid-command aborts the FSM to IDLE; a partial command is discarded.

Test Plan:
1. ACT b3, 6 cycles later RD b3 (T_RCD=4) -> cmd_valid with codes 1 then 2, bank_open[3]=1, viol_pulse=0, viol_count=0.
2. ACT b5, RD b5 at distance 2 -> viol_pulse[0]=1 for 1 cycle, viol_sticky[0]=1, viol_count=1.
3. RD b7 with no prior ACT, then ACT b7 twice at distance 10 -> bit3 on RD, bit4 on second ACT, viol_count=2.
4. ACT b0, REF, PREA, REF, ACT b1 at distance 5 from second REF (T_RFC=20) -> bits 5 and 6 set, bank_open=16'h0002.
5. REF, then no REF for T_REFI_MAX cycles -> bit7 pulses exactly once at cycle 800 after the REF issue cycle. A following REF re-arms the check with no pulse.
6. Beat0 7'h55 -> cmd_code=7, bit8. Beat0 ACT then cs=1 on beat1 -> bit9. With 256 forced violations and ERR_W=8 -> viol_count=255. Pulse clr -> count=0, sticky=0. Assert ddr_reset_n low mid-command -> all outputs 0 immediately.
